tile_addr_gen: RTL and testbench

- Parametrised tile-replicating ROM address generator for the VGA pixel pipeline.
- Maps the current raster position to a tile-ROM address, so one TILE_W x TILE_H bitmap is repeated across the active area.
- Adds run-time horizontal/vertical mirroring, per-frame scroll offsets, a valid flag and tile indices.
- Sits between the VGA sync counter and the tile ROM, in the same slot as the fixed 640x480 / 80x60 generator it supersedes.

---
 rtl/tile_addr_gen_if.sv | 28 ++
 rtl/tile_addr_gen.sv | 164 ++++++++++++++++
 tb/tb_tile_addr_gen.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/tile_addr_gen_if.sv
// Raster-position / tile-ROM address bundle between the sync counter and the tile ROM.
interface tile_addr_gen_if #(
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned TIDX_W = 4
);
  logic [CNT_W-1:0]  pixel_x;
  logic [CNT_W-1:0]  pixel_y;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  scroll_x;
  logic [CNT_W-1:0]  scroll_y;
  logic [ADDR_W-1:0] rom_address;
  logic              addr_valid;
  logic [TIDX_W-1:0] tile_col;
  logic [TIDX_W-1:0] tile_row;

  // Raster/control source side: drives position and controls, observes the address.
  modport master (
    output pixel_x, pixel_y, mode, scroll_x, scroll_y,
    input  rom_address, addr_valid, tile_col, tile_row
  );

  // Address generator side.
  modport slave (
    input  pixel_x, pixel_y, mode, scroll_x, scroll_y,
    output rom_address, addr_valid, tile_col, tile_row
  );
endinterface

// File: rtl/tile_addr_gen.sv
// Tile-replicating ROM address generator with mirroring, per-frame scroll and tile indices.
// Raster trackers follow pixel_x/pixel_y with wrap counters only (no divide/modulo);
// scroll is applied afterwards as a single conditional wrap, so reset can clear the
// shadows mid-frame without losing track of the raster position.
module tile_addr_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned TILE_W   = 80,
  parameter int unsigned TILE_H   = 60,
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned TIDX_W   = 4
) (
  input  logic           clk,
  input  logic           rst,
  tile_addr_gen_if.slave bus
);

  localparam int unsigned BW = ADDR_W + 1;
  localparam int unsigned XW = CNT_W + 1;

  localparam logic [CNT_W-1:0] H_END     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_END     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] TW_M1     = CNT_W'(TILE_W - 1);
  localparam logic [CNT_W-1:0] TH_M1     = CNT_W'(TILE_H - 1);
  localparam logic [CNT_W-1:0] TW_C      = CNT_W'(TILE_W);
  localparam logic [CNT_W-1:0] TH_C      = CNT_W'(TILE_H);
  localparam logic [XW-1:0]    TW_X      = XW'(TILE_W);
  localparam logic [XW-1:0]    TH_X      = XW'(TILE_H);
  localparam logic [BW-1:0]    TW_B      = BW'(TILE_W);
  localparam logic [BW-1:0]    TILE_SZ   = BW'(TILE_W * TILE_H);
  localparam logic [BW-1:0]    LAST_BASE = BW'((TILE_H - 1) * TILE_W);

  // Shift-and-add by the constant tile width; only used once per frame on the scroll shadow.
  function automatic logic [BW-1:0] times_tile_w(input logic [CNT_W-1:0] v);
    logic [BW-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(CNT_W); i++) begin
      if (v[i]) acc = acc + (TW_B << i);
    end
    return acc;
  endfunction

  // Raster trackers (scroll-free): x mod TILE_W, x / TILE_W, y mod TILE_H, y / TILE_H, row base.
  logic [CNT_W-1:0]  xmod_q, ymod_q;
  logic [TIDX_W-1:0] xcol_q, yrow_q;
  logic [BW-1:0]     ybase_q;
  logic [CNT_W-1:0]  xmod_c, ymod_c;
  logic [TIDX_W-1:0] xcol_c, yrow_c;
  logic [BW-1:0]     ybase_c;

  // Per-frame shadows.
  logic [1:0]       mode_s;
  logic [CNT_W-1:0] sx_s, sy_s;
  logic [BW-1:0]    sy_base_s;

  logic [CNT_W-1:0]  sx_sat_c, sy_sat_c;
  logic              active_c, frame_edge_c;
  logic [XW-1:0]     gx_sum_c, gy_sum_c;
  logic [CNT_W-1:0]  lx_c;
  logic [BW-1:0]     base_c;
  logic [TIDX_W-1:0] col_c, row_c;
  logic [ADDR_W-1:0] addr_c;

  // Horizontal tracker value for the pixel currently presented.
  always_comb begin
    xmod_c = '0;
    xcol_c = '0;
    if (bus.pixel_x != '0) begin
      if (xmod_q == TW_M1) begin
        xmod_c = '0;
        xcol_c = xcol_q + TIDX_W'(1);
      end else begin
        xmod_c = xmod_q + CNT_W'(1);
        xcol_c = xcol_q;
      end
    end
  end

  // Vertical tracker advances once per line start, restarts on the first line.
  always_comb begin
    ymod_c  = ymod_q;
    yrow_c  = yrow_q;
    ybase_c = ybase_q;
    if (bus.pixel_x == '0) begin
      if (bus.pixel_y == '0) begin
        ymod_c  = '0;
        yrow_c  = '0;
        ybase_c = '0;
      end else if (ymod_q == TH_M1) begin
        ymod_c  = '0;
        yrow_c  = yrow_q + TIDX_W'(1);
        ybase_c = '0;
      end else begin
        ymod_c  = ymod_q + CNT_W'(1);
        yrow_c  = yrow_q;
        ybase_c = ybase_q + TW_B;
      end
    end
  end

  // Scroll (one conditional wrap per axis), mirroring and final address.
  always_comb begin
    active_c     = (bus.pixel_x < H_END) && (bus.pixel_y < V_END);
    frame_edge_c = (bus.pixel_x == H_END) && (bus.pixel_y == V_END);
    sx_sat_c     = (bus.scroll_x >= TW_C) ? TW_M1 : bus.scroll_x;
    sy_sat_c     = (bus.scroll_y >= TH_C) ? TH_M1 : bus.scroll_y;

    gx_sum_c = XW'(xmod_c) + XW'(sx_s);
    lx_c     = CNT_W'(gx_sum_c);
    col_c    = xcol_c;
    if (gx_sum_c >= TW_X) begin
      lx_c  = CNT_W'(gx_sum_c - TW_X);
      col_c = xcol_c + TIDX_W'(1);
    end

    gy_sum_c = XW'(ymod_c) + XW'(sy_s);
    base_c   = ybase_c + sy_base_s;
    row_c    = yrow_c;
    if (gy_sum_c >= TH_X) begin
      base_c = base_c - TILE_SZ;
      row_c  = yrow_c + TIDX_W'(1);
    end

    if (mode_s[0]) lx_c = TW_M1 - lx_c;
    if (mode_s[1]) base_c = LAST_BASE - base_c;
    addr_c = ADDR_W'(base_c + BW'(lx_c));
  end

  // Raster trackers follow the sync counter regardless of reset.
  always_ff @(posedge clk) begin
    xmod_q  <= xmod_c;
    xcol_q  <= xcol_c;
    ymod_q  <= ymod_c;
    yrow_q  <= yrow_c;
    ybase_q <= ybase_c;
  end

  // Shadow load at the frame boundary and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_s          <= '0;
      sx_s            <= '0;
      sy_s            <= '0;
      sy_base_s       <= '0;
      bus.addr_valid  <= 1'b0;
      bus.rom_address <= '0;
      bus.tile_col    <= '0;
      bus.tile_row    <= '0;
    end else begin
      if (frame_edge_c) begin
        mode_s    <= bus.mode;
        sx_s      <= sx_sat_c;
        sy_s      <= sy_sat_c;
        sy_base_s <= times_tile_w(sy_sat_c);
      end
      bus.addr_valid  <= active_c;
      bus.rom_address <= active_c ? addr_c : '0;
      bus.tile_col    <= active_c ? col_c : '0;
      bus.tile_row    <= active_c ? row_c : '0;
    end
  end

endmodule

// File: tb/tb_tile_addr_gen.sv
// Bench for tile_addr_gen: directed frames with spot values plus randomized frames,
// all checked against a divide/modulo reference model with its own shadow registers.
module tb_tile_addr_gen;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int TILE_W   = 80;
  localparam int TILE_H   = 60;
  localparam int ADDR_W   = 13;
  localparam int CNT_W    = 10;
  localparam int TIDX_W   = 4;
  localparam int FULL     = H_ACTIVE + 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tile_addr_gen_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .TIDX_W(TIDX_W)) bus ();

  tile_addr_gen #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .TILE_W(TILE_W), .TILE_H(TILE_H),
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIDX_W(TIDX_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int ph; int x; int y; int addr; int valid; int col; int row;
  } spot_t;

  spot_t spots[$];
  int    lens[V_ACTIVE];
  int    vectors = 0;
  int    checks = 0;
  int    miscompares = 0;
  int    m_mode, m_sx, m_sy;
  int    phase = 0;
  int    rst_x = -1, rst_y = -1;
  int    chg_x = -1, chg_y = -1, chg_mode = 0;
  bit    rand_in = 1'b0;

  task automatic chk(input string tag, input int x, input int y, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at (%0d,%0d): observed %0d expected %0d", tag, x, y, obs, exp);
    end
  endtask

  // Reference: address straight from the raster position with divide/modulo.
  task automatic model(input int x, input int y, input bit r,
                       output int ea, output int ev, output int ec, output int er);
    int gx, gy, lx, ly;
    ea = 0; ev = 0; ec = 0; er = 0;
    if (!r && x < H_ACTIVE && y < V_ACTIVE) begin
      gx = x + m_sx;
      gy = y + m_sy;
      lx = gx % TILE_W;
      ly = gy % TILE_H;
      if (m_mode % 2 == 1) lx = TILE_W - 1 - lx;
      if (m_mode / 2 == 1) ly = TILE_H - 1 - ly;
      ea = ly * TILE_W + lx;
      ev = 1;
      ec = (gx / TILE_W) % (1 << TIDX_W);
      er = (gy / TILE_H) % (1 << TIDX_W);
    end
  endtask

  task automatic rand_inputs();
    bus.mode     = 2'($urandom_range(0, 3));
    bus.scroll_x = CNT_W'($urandom_range(0, 100));
    bus.scroll_y = CNT_W'($urandom_range(0, 75));
  endtask

  task automatic step(input int x, input int y, input bit force_rst);
    bit r;
    int ea, ev, ec, er, sxi, syi;
    r = force_rst || (x == rst_x && y == rst_y);
    if (x == chg_x && y == chg_y) bus.mode = 2'(chg_mode);
    if (rand_in && $urandom_range(0, 63) == 0) rand_inputs();
    bus.pixel_x = CNT_W'(x);
    bus.pixel_y = CNT_W'(y);
    rst = r;
    model(x, y, r, ea, ev, ec, er);
    @(posedge clk);
    #1;
    vectors++;
    chk("rom_address", x, y, int'(bus.rom_address), ea);
    chk("addr_valid",  x, y, int'(bus.addr_valid),  ev);
    chk("tile_col",    x, y, int'(bus.tile_col),    ec);
    chk("tile_row",    x, y, int'(bus.tile_row),    er);
    foreach (spots[i]) begin
      if (spots[i].ph == phase && spots[i].x == x && spots[i].y == y) begin
        chk("spot_addr",  x, y, int'(bus.rom_address), spots[i].addr);
        chk("spot_valid", x, y, int'(bus.addr_valid),  spots[i].valid);
        chk("spot_col",   x, y, int'(bus.tile_col),    spots[i].col);
        chk("spot_row",   x, y, int'(bus.tile_row),    spots[i].row);
      end
    end
    if (r) begin
      m_mode = 0; m_sx = 0; m_sy = 0;
    end else if (x == H_ACTIVE && y == V_ACTIVE) begin
      sxi    = int'(bus.scroll_x);
      syi    = int'(bus.scroll_y);
      m_mode = int'(bus.mode);
      m_sx   = (sxi >= TILE_W) ? TILE_W - 1 : sxi;
      m_sy   = (syi >= TILE_H) ? TILE_H - 1 : syi;
    end
  endtask

  task automatic run_line(input int y, input int n);
    for (int x = 0; x < n; x++) step(x, y, 1'b0);
  endtask

  task automatic run_frame();
    for (int y = 0; y < V_ACTIVE; y++) run_line(y, lens[y]);
  endtask

  task automatic set_lens(input bit rnd);
    for (int y = 0; y < V_ACTIVE; y++) begin
      if (!rnd) lens[y] = 1;
      else if ($urandom_range(0, 39) == 0) lens[y] = FULL;
      else lens[y] = $urandom_range(1, 6);
    end
  endtask

  initial begin
    spots.push_back('{1,   0,   0,    0, 1, 0, 0});
    spots.push_back('{1,  79,   0,   79, 1, 0, 0});
    spots.push_back('{1,  80,   0,    0, 1, 1, 0});
    spots.push_back('{1,   0,   1,   80, 1, 0, 0});
    spots.push_back('{1, 639, 479, 4799, 1, 7, 7});
    spots.push_back('{2,   0,   0,   79, 1, 0, 0});
    spots.push_back('{2,  79,   0,    0, 1, 0, 0});
    spots.push_back('{2,   5,   2,  234, 1, 0, 0});
    spots.push_back('{3,   0,   0, 4799, 1, 0, 0});
    spots.push_back('{3,  10,  59,   69, 1, 0, 0});
    spots.push_back('{3,  80,  60, 4799, 1, 1, 1});
    spots.push_back('{4,   0,   0,  410, 1, 0, 0});
    spots.push_back('{4,  70,   0,  400, 1, 1, 0});
    spots.push_back('{5,   1,   0,  400, 1, 1, 0});
    spots.push_back('{6, 300, 200, 1660, 1, 3, 3});
    spots.push_back('{6, 639, 479, 4799, 1, 7, 7});
    spots.push_back('{7,   0,   0, 4799, 1, 0, 0});
    spots.push_back('{7, 640,  10,    0, 0, 0, 0});
    spots.push_back('{7, 122,  45, 1157, 1, 1, 0});
    spots.push_back('{7, 123,  45,    0, 0, 0, 0});
    spots.push_back('{7, 124,  45, 3644, 1, 1, 0});
    spots.push_back('{7,   0,  46, 3680, 1, 0, 0});

    m_mode = 0; m_sx = 0; m_sy = 0;
    rst = 1'b1;
    bus.pixel_x  = '0;
    bus.pixel_y  = '0;
    bus.mode     = 2'b00;
    bus.scroll_x = '0;
    bus.scroll_y = '0;

    // Reset during a blanking line, then cross the first frame boundary.
    for (int x = 0; x < FULL; x++) step(x, V_ACTIVE, x < 3);

    // Plain replication, mode 00, no scroll.
    phase = 1; set_lens(1'b0);
    lens[0] = FULL; lens[1] = 2; lens[479] = FULL;
    run_frame();
    bus.mode = 2'b01;
    run_line(V_ACTIVE, FULL);

    // Horizontal mirror.
    phase = 2; set_lens(1'b0);
    lens[0] = 80; lens[2] = 6;
    run_frame();
    bus.mode = 2'b11;
    run_line(V_ACTIVE, FULL);

    // Both mirrors.
    phase = 3; set_lens(1'b0);
    lens[59] = 11; lens[60] = 81;
    run_frame();
    bus.mode = 2'b00; bus.scroll_x = CNT_W'(10); bus.scroll_y = CNT_W'(5);
    run_line(V_ACTIVE, FULL);

    // Scroll 10/5.
    phase = 4; set_lens(1'b0);
    lens[0] = 71;
    run_frame();
    bus.scroll_x = CNT_W'(200);
    run_line(V_ACTIVE, FULL);

    // Saturated horizontal scroll.
    phase = 5; set_lens(1'b0);
    lens[0] = 2;
    run_frame();
    bus.scroll_x = '0; bus.scroll_y = '0;
    run_line(V_ACTIVE, FULL);

    // Mode change mid-frame must wait for the next boundary.
    phase = 6; set_lens(1'b0);
    lens[200] = FULL; lens[479] = FULL;
    chg_x = 300; chg_y = 200; chg_mode = 3;
    run_frame();
    chg_x = -1; chg_y = -1;
    run_line(V_ACTIVE, FULL);

    // Mirrored frame, blanking, and a mid-frame reset.
    phase = 7; set_lens(1'b0);
    lens[10] = FULL; lens[45] = FULL;
    rst_x = 123; rst_y = 45;
    run_frame();
    rst_x = -1; rst_y = -1;
    rand_inputs();
    run_line(V_ACTIVE, FULL);

    // Randomized frames with random line lengths and random control changes.
    phase = 0;
    rand_in = 1'b1;
    repeat (3) begin
      set_lens(1'b1);
      run_frame();
      run_line(V_ACTIVE, FULL);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
